// File: rtl/mul_job_dispatcher_if.sv
// rtl/mul_job_dispatcher_if.sv - handshake bundle for the multiplier job dispatcher
//
// Purpose: groups the three handshakes the dispatcher sits between so they
// travel as one port.
//   operand stream : in_valid, in_ready, in_a, in_b
//   result stream  : out_valid, out_ready, out_product, out_err
//   multiplier bus : mul_start, mul_multiplier, mul_multiplicand,
//                    mul_ready, mul_product
// Modports:
//   slave  - the dispatcher (accepts operands, drives results and the multiplier)
//   master - the surrounding environment (feeder, consumer and multiplier)

interface mul_job_dispatcher_if #(
  parameter int N = 8
);

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;

  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_product;
  logic           out_err;

  logic           mul_start;
  logic [N-1:0]   mul_multiplier;
  logic [N-1:0]   mul_multiplicand;
  logic           mul_ready;
  logic [2*N-1:0] mul_product;

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    output in_ready,
    output out_valid,
    output out_product,
    output out_err,
    input  out_ready,
    output mul_start,
    output mul_multiplier,
    output mul_multiplicand,
    input  mul_ready,
    input  mul_product
  );

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    input  in_ready,
    input  out_valid,
    input  out_product,
    input  out_err,
    output out_ready,
    input  mul_start,
    input  mul_multiplier,
    input  mul_multiplicand,
    output mul_ready,
    output mul_product
  );

endinterface

// File: rtl/mul_job_dispatcher.sv
// rtl/mul_job_dispatcher.sv - FIFO-buffered job feeder for a sequential multiplier
//
// Purpose: buffers operand pairs in a DEPTH-entry FIFO, launches one job at a
// time on the multiplier with a single-cycle start pulse, captures the product
// when the multiplier reports ready (or flags a timeout error when it never
// does) and holds the result on the output stream until it is accepted.
//
// Ports:
//   clk         - clock, all state changes on the rising edge
//   rst_n       - synchronous active-low reset
//   bus         - mul_job_dispatcher_if.slave
//                   in_*  : operand stream (pair accepted on in_valid && in_ready)
//                   out_* : result stream (out_err qualified by out_valid)
//                   mul_* : start pulse, operands, ready and product of the multiplier
//   busy        - a job is in flight (FSM outside IDLE)
//   fifo_count  - number of queued operand pairs

module mul_job_dispatcher #(
  parameter int N       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mul_job_dispatcher_if.slave      bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_ARM    = 3'd2,
    S_WAIT   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t state;
  state_t state_d;

  // FIFO storage: each entry is {a, b}
  logic [2*N-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [2*N-1:0] head;
  logic           push;
  logic           pop;

  logic [WW-1:0]  watchdog;
  logic [WW-1:0]  watchdog_d;
  logic           wd_expired;

  // next values of the registered outputs
  logic           mul_start_d;
  logic [N-1:0]   opa_d;
  logic [N-1:0]   opb_d;
  logic           out_valid_d;
  logic           out_err_d;
  logic [2*N-1:0] out_product_d;
  logic           busy_d;

  // in_ready looks only at the registered count, so a full FIFO refuses a
  // push even in the cycle it is being popped.
  assign bus.in_ready = (fifo_count != CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == S_IDLE) && (fifo_count != CW'(0)) && !bus.out_valid;
  assign head         = mem[rd_ptr];
  assign wd_expired   = (watchdog == WW'(TIMEOUT - 1));

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_a, bus.in_b};
    end
  end

  // Pointers are AW bits wide, so incrementing wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ------------------------------------------------------ state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ------------------------------------------------------ next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (pop) begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_ARM;
      // ARM is a guard cycle: mul_ready may still be the stale idle level.
      S_ARM:    state_d = S_WAIT;
      S_WAIT: begin
        if (bus.mul_ready || wd_expired) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- output logic
  // Computes the next value of every registered output from the current
  // state; mul_start and busy are decoded from the state being entered so
  // that they line up with LAUNCH and with the non-IDLE states.
  always_comb begin
    mul_start_d   = (state_d == S_LAUNCH);
    busy_d        = (state_d != S_IDLE);
    opa_d         = bus.mul_multiplier;
    opb_d         = bus.mul_multiplicand;
    out_valid_d   = bus.out_valid;
    out_err_d     = bus.out_err;
    out_product_d = bus.out_product;
    watchdog_d    = watchdog;
    unique case (state)
      S_IDLE: begin
        if (pop) begin
          {opa_d, opb_d} = head;
        end
      end
      S_ARM: begin
        watchdog_d = '0;
      end
      S_WAIT: begin
        if (bus.mul_ready) begin
          out_product_d = bus.mul_product;
          out_err_d     = 1'b0;
          out_valid_d   = 1'b1;
        end else if (wd_expired) begin
          out_product_d = '0;
          out_err_d     = 1'b1;
          out_valid_d   = 1'b1;
        end else begin
          watchdog_d = watchdog + WW'(1);
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.mul_start        <= 1'b0;
      bus.mul_multiplier   <= '0;
      bus.mul_multiplicand <= '0;
      bus.out_valid        <= 1'b0;
      bus.out_err          <= 1'b0;
      bus.out_product      <= '0;
      busy                 <= 1'b0;
      watchdog             <= '0;
    end else begin
      bus.mul_start        <= mul_start_d;
      bus.mul_multiplier   <= opa_d;
      bus.mul_multiplicand <= opb_d;
      bus.out_valid        <= out_valid_d;
      bus.out_err          <= out_err_d;
      bus.out_product      <= out_product_d;
      busy                 <= busy_d;
      watchdog             <= watchdog_d;
    end
  end

endmodule

// File: tb/tb_mul_job_dispatcher.sv
// tb/tb_mul_job_dispatcher.sv - self-checking bench for mul_job_dispatcher

module tb_mul_job_dispatcher;

  localparam int N       = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  typedef logic [2*N-1:0] pair_t;
  typedef logic [2*N:0]   res_t;

  logic                   clk   = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;

  mul_job_dispatcher_if #(.N(N)) bus ();

  mul_job_dispatcher #(
    .N       (N),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: queued pairs, delivered results {err, product}, job in flight
  pair_t          in_q[$];
  res_t           got_q[$];
  bit             in_flight  = 1'b0;
  pair_t          cur        = '0;
  bit             cur_hang   = 1'b0;
  int             starts     = 0;
  int             cyc        = 0;
  int             launch_cyc = 0;
  int             last_lat   = 0;
  bit             prev_valid = 1'b0;
  bit             prev_err   = 1'b0;
  bit             hs_pending = 1'b0;
  logic [2*N-1:0] prev_prod  = '0;

  // multiplier model: ready stays high (stale) through ARM, drops in the
  // first WAIT cycle, rises with the product lat cycles after the start.
  bit m_ph   = 1'b0;
  int m_step = 0;
  int lat    = 3;
  bit hang   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2*N-1:0] prod(input pair_t p);
    logic [2*N-1:0] a;
    logic [2*N-1:0] b;
    a = {{N{1'b0}}, p[2*N-1:N]};
    b = {{N{1'b0}}, p[N-1:0]};
    return a * b;
  endfunction

  task automatic model_step();
    cyc++;
    if (!rst_n) begin
      in_q.delete();
      in_flight       = 1'b0;
      prev_valid      = 1'b0;
      hs_pending      = 1'b0;
      m_ph            = 1'b0;
      bus.mul_ready   = 1'b1;
      bus.mul_product = '0;
      return;
    end
    if (hs_pending) begin
      got_q.push_back({prev_err, prev_prod});
      in_flight = 1'b0;
      check("valid_after_accept", bus.out_valid, 0);
    end else if (prev_valid) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_product", bus.out_product, prev_prod);
      check("hold_err", bus.out_err, prev_err);
    end
    if (bus.mul_start) begin
      check("start_allowed", {30'd0, in_flight, in_q.size() == 0}, 0);
      if (in_q.size() != 0) begin
        cur = in_q.pop_front();
      end
      in_flight       = 1'b1;
      cur_hang        = hang;
      starts++;
      launch_cyc      = cyc;
      check("launch_a", bus.mul_multiplier, cur[2*N-1:N]);
      check("launch_b", bus.mul_multiplicand, cur[N-1:0]);
      m_ph            = 1'b1;
      m_step          = 0;
      bus.mul_product = 16'hDEAD;
    end else if (m_ph) begin
      m_step++;
      if (m_step == 2) begin
        bus.mul_ready = 1'b0;
      end
      if (m_step >= lat && !hang) begin
        bus.mul_ready   = 1'b1;
        bus.mul_product = prod(cur);
        m_ph            = 1'b0;
      end
    end
    if (bus.out_valid && !prev_valid) begin
      check("valid_needs_job", in_flight, 1);
      last_lat = cyc - launch_cyc;
      check("result_err", bus.out_err, cur_hang);
      check("result_product", bus.out_product, cur_hang ? '0 : prod(cur));
    end
    check("busy", busy, in_flight);
    check("fifo_count", fifo_count, in_q.size());
    check("in_ready", bus.in_ready, in_q.size() != DEPTH);
    if (bus.in_valid && in_q.size() != DEPTH) begin
      in_q.push_back({bus.in_a, bus.in_b});
    end
    prev_valid = bus.out_valid;
    prev_prod  = bus.out_product;
    prev_err   = bus.out_err;
    hs_pending = bus.out_valid && bus.out_ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
    bit done;
    done       = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    check("push_accepted", {31'd0, done}, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("results_count", got_q.size(), n);
    tick();
  endtask

  task automatic check_got(input string name, input int idx, input res_t exp);
    check(name, (idx < got_q.size()) ? {15'd0, got_q[idx]} : 32'hFFFF_FFFF, {15'd0, exp});
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_fifo_count"}, fifo_count, 0);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_err"}, bus.out_err, 0);
    check({tag, "_out_product"}, bus.out_product, 0);
    check({tag, "_mul_start"}, bus.mul_start, 0);
    check({tag, "_mul_multiplier"}, bus.mul_multiplier, 0);
    check({tag, "_mul_multiplicand"}, bus.mul_multiplicand, 0);
    check({tag, "_busy"}, busy, 0);
    tick();
  endtask

  initial begin
    int stalled;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    fork
      forever begin
        @(negedge clk);
        model_step();
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_values("reset");

    // single job
    lat = 3;
    push(8'h0C, 8'h0A);
    wait_results(1, 50);
    check_got("t1_product", 0, 17'h0_0078);
    check("t1_starts", starts, 1);
    check("t1_latency", last_lat, 4);
    check("t1_busy_done", busy, 0);

    // maximum operands
    push(8'hFF, 8'hFF);
    push(8'h00, 8'h37);
    wait_results(3, 100);
    check_got("t2_ff_ff", 1, 17'h0_FE01);
    check_got("t2_zero", 2, 17'h0_0000);
    check("t2_starts", starts, 3);

    // backpressure
    bus.out_ready = 1'b0;
    push(8'h01, 8'h02);
    push(8'h03, 8'h04);
    push(8'h05, 8'h06);
    push(8'h07, 8'h08);
    push(8'h09, 8'h0A);
    repeat (20) tick();
    @(negedge clk);
    #1;
    check("t3_full_count", fifo_count, 4);
    check("t3_full_ready", bus.in_ready, 0);
    check("t3_held_valid", bus.out_valid, 1);
    check("t3_held_product", bus.out_product, 16'h0002);
    check("t3_starts", starts, 4);
    tick();
    bus.out_ready = 1'b1;
    wait_results(8, 200);
    check_got("t3_r0", 3, 17'h0_0002);
    check_got("t3_r1", 4, 17'h0_000C);
    check_got("t3_r2", 5, 17'h0_001E);
    check_got("t3_r3", 6, 17'h0_0038);
    check_got("t3_r4", 7, 17'h0_005A);

    // push while full: held in_valid is taken once the pop frees a slot
    bus.out_ready = 1'b0;
    push(8'h10, 8'h10);
    push(8'h20, 8'h03);
    push(8'h40, 8'h04);
    push(8'h80, 8'h02);
    push(8'h11, 8'h11);
    repeat (10) tick();
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'h0B;
    bus.in_b      = 8'h0D;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    stalled = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("t4_pop_cycle_count", fifo_count, 4);
      end
      if (bus.in_ready) begin
        break;
      end
      stalled++;
    end
    tick();
    bus.in_valid = 1'b0;
    check("t4_stalled_cycles", stalled, 1);
    @(negedge clk);
    #1;
    check("t4_count_after", fifo_count, 4);
    check("t4_starts", starts, 10);
    tick();
    bus.out_ready = 1'b1;
    wait_results(14, 300);
    check_got("t4_first", 8, 17'h0_0100);
    check_got("t4_second", 9, 17'h0_0060);
    check_got("t4_extra", 13, 17'h0_008F);

    // watchdog timeout, then a normal job
    hang = 1'b1;
    push(8'h03, 8'h05);
    wait_results(15, 200);
    check_got("t5_timeout", 14, 17'h1_0000);
    check("t5_timeout_latency", last_lat, TIMEOUT + 2);
    hang = 1'b0;
    tick();
    push(8'h06, 8'h07);
    wait_results(16, 100);
    check_got("t5_recover", 15, 17'h0_002A);
    check("t5_recover_latency", last_lat, 4);

    // reset in the middle of a job with two pairs queued
    lat = 20;
    push(8'h01, 8'h01);
    push(8'h02, 8'h02);
    push(8'h03, 8'h03);
    tick();
    tick();
    @(negedge clk);
    #1;
    check("t6_busy_before", busy, 1);
    check("t6_count_before", fifo_count, 2);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_values("t6");
    repeat (40) tick();
    check("t6_no_results", got_q.size(), 16);
    check("t6_no_valid", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
